codificatore_sequenziale: RTL and testbench

CODIFICATORE_SEQUENZIALE -- requirements
Module: codificatore_sequenziale

---
 rtl/codificatore_pkg.sv | 30 +++
 rtl/codificatore_prio_enc8.sv | 30 +++
 rtl/codificatore_sequenziale.sv | 129 ++++++++++++
 tb/tb_codificatore_sequenziale.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/codificatore_pkg.sv
// -----------------------------------------------------------------------------
// codificatore_pkg
// Shared types and constants for the sequential priority encoder.
//   state_e   : FSM states (IDLE waits for a word, SCAN emits its beats)
//   W_REQ     : request vector width (8)
//   W_IDX     : index width (3)
//   W_CNT     : popcount width (4, holds 0..8)
//   popcount(): number of set bits in a request word
// -----------------------------------------------------------------------------
package codificatore_pkg;

    localparam int W_REQ = 8;
    localparam int W_IDX = 3;
    localparam int W_CNT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic logic [W_CNT-1:0] popcount(input logic [W_REQ-1:0] v);
        logic [W_CNT-1:0] n;
        n = '0;
        for (int i = 0; i < W_REQ; i++) begin
            n = n + W_CNT'(v[i]);
        end
        return n;
    endfunction

endpackage : codificatore_pkg

// File: rtl/codificatore_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational lowest-set-bit encoder (bit 0 has the highest priority).
//   vec_i : 8-bit input vector
//   idx_o : index of the lowest set bit (0 when vec_i is all zeros)
//   any_o : 1 when at least one bit of vec_i is set
// -----------------------------------------------------------------------------
module prio_enc8
    import codificatore_pkg::*;
(
    input  logic [W_REQ-1:0] vec_i,
    output logic [W_IDX-1:0] idx_o,
    output logic             any_o
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        // Walk from the top bit down so the last hit is the lowest set bit.
        for (int i = W_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = W_IDX'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule : prio_enc8

// File: rtl/codificatore_sequenziale.sv
// -----------------------------------------------------------------------------
// codificatore_sequenziale
// Captures an 8-bit request word and emits one beat per set bit, lowest index
// first, over a valid/ready handshake. An all-zero word emits a single beat
// flagged with none=1.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in_valid   : req holds a word to capture
//   in_ready   : block can accept a word (IDLE)
//   req[7:0]   : request vector, bit n set = source n active
//   out_valid  : idx/last/none hold a valid beat (SCAN)
//   out_ready  : consumer accepts the current beat
//   idx[2:0]   : index of the current active bit
//   last       : current beat is the final beat of the word
//   none       : captured word was all zeros
//   cnt[3:0]   : popcount of the captured word (only with CODIFICATORE_COUNT_EN)
//
// Configuration
//   CODIFICATORE_COUNT_EN : when defined, adds the cnt output and its register.
// -----------------------------------------------------------------------------
module codificatore_sequenziale
    import codificatore_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_REQ-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_IDX-1:0] idx,
    output logic             last,
    output logic             none
`ifdef CODIFICATORE_COUNT_EN
    ,
    output logic [W_CNT-1:0] cnt
`endif
);

    state_e           state_q, state_d;
    logic [W_REQ-1:0] shadow_q, shadow_d;
    logic             none_q, none_d;
`ifdef CODIFICATORE_COUNT_EN
    logic [W_CNT-1:0] cnt_q, cnt_d;
`endif

    logic [W_IDX-1:0] enc_idx;
    logic             enc_any;
    logic             one_left;
    logic             scan;

    prio_enc8 u_prio_enc8 (
        .vec_i (shadow_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    assign one_left = enc_any && ((shadow_q & (shadow_q - W_REQ'(1))) == '0);
    assign scan     = (state_q == SCAN);

    // Outputs depend only on registered state, so they cannot change while a
    // beat is stalled.
    assign in_ready  = ~scan;
    assign out_valid = scan;
    assign idx       = enc_idx;
    assign last      = scan && (none_q || one_left);
    assign none      = scan && none_q;
`ifdef CODIFICATORE_COUNT_EN
    assign cnt       = cnt_q;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        none_d   = none_q;
`ifdef CODIFICATORE_COUNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SCAN;
                    shadow_d = req;
                    none_d   = (req == '0);
`ifdef CODIFICATORE_COUNT_EN
                    cnt_d    = popcount(req);
`endif
                end
            end
            SCAN: begin
                if (out_ready) begin
                    // Retire the bit just sent; a zero word stays zero.
                    shadow_d = shadow_q & ~(W_REQ'(1) << enc_idx);
                    if (last) begin
                        state_d = IDLE;
                        none_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the shadow register is reset along with the FSM so a reset in SCAN
    // leaves no stale bits behind to leak into idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            none_q   <= 1'b0;
`ifdef CODIFICATORE_COUNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            none_q   <= none_d;
`ifdef CODIFICATORE_COUNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule : codificatore_sequenziale

// File: tb/tb_codificatore_sequenziale.sv
// -----------------------------------------------------------------------------
// tb_codificatore_sequenziale
// Self-checking bench for codificatore_sequenziale. Inputs are driven and
// outputs sampled on the falling clock edge. The expected beat list for a word
// is built from its set bits in ascending order (or a single none beat for a
// zero word). Define CODIFICATORE_COUNT_EN to also check cnt.
// -----------------------------------------------------------------------------
module tb_codificatore_sequenziale;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] idx;
    logic       last;
    logic       none;
`ifdef CODIFICATORE_COUNT_EN
    logic [3:0] cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    codificatore_sequenziale dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .last      (last),
        .none      (none)
`ifdef CODIFICATORE_COUNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ascending list of set-bit positions; a zero word is one beat at 0.
    task automatic expected_beats(input logic [7:0] w, output int beats[$]);
        beats = {};
        for (int b = 0; b < 8; b++) if (w[b]) beats.push_back(b);
        if (beats.size() == 0) beats.push_back(0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Offer word w, then consume all of its beats. The first hold cycles keep
    // out_ready low, afterwards out_ready is low with probability stall_pct.
    // With noise set, in_valid stays high with random req during SCAN.
    task automatic run_word(input string tag, input logic [7:0] w, input int hold,
                            input int stall_pct, input bit noise);
        int  beats[$];
        int  n, beat, cycles;
        bit  rdy;
        expected_beats(w, beats);
        n = beats.size();
        @(negedge clk);
        check_idle({tag, "_pre"});
        in_valid  = 1'b1;
        req       = w;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = noise;
        req      = noise ? 8'($urandom) : 8'h00;
        beat   = 0;
        cycles = 0;
        while (beat < n && cycles < 200) begin
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_in_ready"},  32'(in_ready),  32'd0);
            check({tag, "_idx"},       32'(idx),       32'(beats[beat]));
            check({tag, "_last"},      32'(last),      32'(beat == n - 1));
            check({tag, "_none"},      32'(none),      32'(w == 8'h00));
`ifdef CODIFICATORE_COUNT_EN
            check({tag, "_cnt"},       32'(cnt),       32'((w == 8'h00) ? 0 : n));
`endif
            rdy = (cycles >= hold) && ($urandom_range(99) >= 32'(stall_pct));
            out_ready = rdy;
            if (noise) req = 8'($urandom);
            @(negedge clk);
            if (rdy) beat++;
            cycles++;
        end
        if (beat < n) check({tag, "_timeout"}, 32'(beat), 32'(n));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_idle({tag, "_post"});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        req       = 8'hA5;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_idx",  32'(idx),  32'd0);
        check("reset_last", 32'(last), 32'd0);
        check("reset_none", 32'(none), 32'd0);
`ifdef CODIFICATORE_COUNT_EN
        check("reset_cnt",  32'(cnt),  32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        req      = 8'h00;

        run_word("single",   8'b0000_0001, 0, 0, 1'b0);
        run_word("sparse",   8'b1010_0100, 0, 0, 1'b0);
        run_word("zero",     8'h00,        0, 0, 1'b0);
        run_word("stall",    8'b0001_1000, 3, 0, 1'b0);
        run_word("all",      8'hFF,        0, 0, 1'b0);
        run_word("noise",    8'b0110_0010, 0, 0, 1'b1);

        // Reset mid-word after three beats, with in_valid/out_ready also high.
        @(negedge clk);
        in_valid  = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("rst_mid_idx", 32'(idx), 32'(b));
            @(negedge clk);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        req      = 8'h3C;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_idle("rst_mid");
        check("rst_mid_idx0",  32'(idx),  32'd0);
        check("rst_mid_last0", 32'(last), 32'd0);
        run_word("after_rst", 8'b1000_0000, 0, 0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            run_word("rand", 8'($urandom), int'($urandom_range(2)), 30, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_codificatore_sequenziale
